clk_en_gen: RTL and testbench

Parametrised multi-channel clock-enable generator. It replaces ripple-divided derived clocks with single-cycle enable strobes and optional toggle outputs, all in the one system clock domain. Each channel has a runtime-programmable divisor, and divisor changes apply glitch-free at the channel's terminal count. A global run gate and a sync/realign input keep all channels phase-locked. It sits at the top of the design and feeds CPU, PPU, APU and video timing enables.

---
 rtl/clk_en_gen.sv | 123 ++++++++++++
 tb/tb_clk_en_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator: per-channel programmable strobe and toggle
// outputs in the single system clock domain, with glitch-free divisor updates.
module clk_en_gen #(
   parameter int unsigned                NUM_CH   = 4,
   parameter int unsigned                DIV_W    = 8,
   parameter logic [NUM_CH*DIV_W-1:0]    DIV_INIT = {8'd15, 8'd7, 8'd3, 8'd1},
   localparam int unsigned               CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              sync,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   output logic [NUM_CH-1:0] stb,
   output logic [NUM_CH-1:0] tog,
   output logic [NUM_CH-1:0] cfg_pending
);

   logic [DIV_W-1:0]  cnt_q      [NUM_CH];
   logic [DIV_W-1:0]  cnt_d      [NUM_CH];
   logic [DIV_W-1:0]  div_act_q  [NUM_CH];
   logic [DIV_W-1:0]  div_act_d  [NUM_CH];
   logic [DIV_W-1:0]  div_pend_q [NUM_CH];
   logic [DIV_W-1:0]  div_pend_d [NUM_CH];
   logic [NUM_CH-1:0] pend_q;
   logic [NUM_CH-1:0] pend_d;
   logic [NUM_CH-1:0] stb_q;
   logic [NUM_CH-1:0] stb_d;
   logic [NUM_CH-1:0] tog_q;
   logic [NUM_CH-1:0] tog_d;
   logic [NUM_CH-1:0] wr_s;

   // Decode the write strobe; an index beyond the last channel selects nothing.
   always_comb begin
      wr_s = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg_we && (cfg_ch == CH_W'(i))) begin
            wr_s[i] = 1'b1;
         end else begin
            wr_s[i] = 1'b0;
         end
      end
   end

   // Per-channel next state: sync beats run, run gates the terminal count.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i]      = cnt_q[i];
         div_act_d[i]  = div_act_q[i];
         div_pend_d[i] = div_pend_q[i];
         pend_d[i]     = pend_q[i];
         stb_d[i]      = 1'b0;
         tog_d[i]      = tog_q[i];

         if (sync) begin
            cnt_d[i] = '0;
            tog_d[i] = 1'b0;
            if (wr_s[i]) begin
               div_act_d[i] = cfg_div;
               pend_d[i]    = 1'b0;
            end else if (pend_q[i]) begin
               div_act_d[i] = div_pend_q[i];
               pend_d[i]    = 1'b0;
            end else begin
               div_act_d[i] = div_act_q[i];
            end
         end else begin
            if (!run) begin
               cnt_d[i] = cnt_q[i];
            end else if (cnt_q[i] == div_act_q[i]) begin
               cnt_d[i] = '0;
               stb_d[i] = 1'b1;
               tog_d[i] = ~tog_q[i];
               if (pend_q[i]) begin
                  div_act_d[i] = div_pend_q[i];
                  pend_d[i]    = 1'b0;
               end else begin
                  div_act_d[i] = div_act_q[i];
               end
            end else begin
               cnt_d[i] = cnt_q[i] + DIV_W'(1'b1);
            end
            // A write landing on the terminal-count edge waits for the next one.
            if (wr_s[i]) begin
               div_pend_d[i] = cfg_div;
               pend_d[i]     = 1'b1;
            end else begin
               div_pend_d[i] = div_pend_q[i];
            end
         end
      end
   end

   // Channel state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]      <= '0;
            div_act_q[i]  <= DIV_INIT[i*DIV_W +: DIV_W];
            div_pend_q[i] <= '0;
         end
         pend_q <= '0;
         stb_q  <= '0;
         tog_q  <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]      <= cnt_d[i];
            div_act_q[i]  <= div_act_d[i];
            div_pend_q[i] <= div_pend_d[i];
         end
         pend_q <= pend_d;
         stb_q  <= stb_d;
         tog_q  <= tog_d;
      end
   end

   assign stb         = stb_q;
   assign tog         = tog_q;
   assign cfg_pending = pend_q;

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen: a countdown-style reference model checked every
// cycle, plus hand-computed strobe intervals and counts.
module tb_clk_en_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, run, sync, cfg_we;
   logic [1:0] cfg_ch;
   logic [7:0] cfg_div;
   logic [3:0] stb, tog, cfg_pending;

   logic       run_b, sync_b, cfg_we_b;
   logic [1:0] cfg_ch_b;
   logic [3:0] cfg_div_b;
   logic [2:0] stb_b, tog_b, pend_b;

   clk_en_gen dut (
      .clk(clk), .rst(rst), .run(run), .sync(sync), .cfg_we(cfg_we),
      .cfg_ch(cfg_ch), .cfg_div(cfg_div), .stb(stb), .tog(tog),
      .cfg_pending(cfg_pending)
   );

   clk_en_gen #(.NUM_CH(3), .DIV_W(4), .DIV_INIT({4'd2, 4'd1, 4'd0})) dut_b (
      .clk(clk), .rst(rst), .run(run_b), .sync(sync_b), .cfg_we(cfg_we_b),
      .cfg_ch(cfg_ch_b), .cfg_div(cfg_div_b), .stb(stb_b), .tog(tog_b),
      .cfg_pending(pend_b)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // Reference model: each channel counts down the run-edges left until its strobe.
   int         init_div [4] = '{1, 3, 7, 15};
   int         m_left [4];
   int         m_div  [4];
   int         m_pdiv [4];
   bit         m_pend [4];
   logic [3:0] m_stb, m_tog, m_pvec;

   function automatic void model_reset();
      for (int c = 0; c < 4; c++) begin
         m_div[c]  = init_div[c];
         m_pdiv[c] = 0;
         m_pend[c] = 1'b0;
         m_left[c] = init_div[c] + 1;
         m_pvec[c] = 1'b0;
      end
      m_stb = 4'b0000;
      m_tog = 4'b0000;
   endfunction

   function automatic void model_step();
      for (int c = 0; c < 4; c++) begin
         bit wr;
         wr = cfg_we && (int'(cfg_ch) == c);
         if (sync) begin
            m_stb[c] = 1'b0;
            m_tog[c] = 1'b0;
            if (wr) begin
               m_div[c]  = int'(cfg_div);
               m_pend[c] = 1'b0;
            end else if (m_pend[c]) begin
               m_div[c]  = m_pdiv[c];
               m_pend[c] = 1'b0;
            end
            m_left[c] = m_div[c] + 1;
         end else begin
            if (!run) begin
               m_stb[c] = 1'b0;
            end else begin
               m_left[c] = m_left[c] - 1;
               if (m_left[c] == 0) begin
                  m_stb[c] = 1'b1;
                  m_tog[c] = ~m_tog[c];
                  if (m_pend[c]) begin
                     m_div[c]  = m_pdiv[c];
                     m_pend[c] = 1'b0;
                  end
                  m_left[c] = m_div[c] + 1;
               end else begin
                  m_stb[c] = 1'b0;
               end
            end
            if (wr) begin
               m_pdiv[c] = int'(cfg_div);
               m_pend[c] = 1'b1;
            end
         end
         m_pvec[c] = m_pend[c];
      end
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) model_reset();
      else      model_step();
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("model_stb", 32'(stb), 32'(m_stb));
         check("model_tog", 32'(tog), 32'(m_tog));
         check("model_pending", 32'(cfg_pending), 32'(m_pvec));
      end
   end

   int cyc;
   int last_s [4];
   int intv   [4];
   int scnt   [4];

   task automatic tick();
      @(negedge clk);
      cyc++;
      for (int c = 0; c < 4; c++) begin
         if (stb[c]) begin
            intv[c]   = cyc - last_s[c];
            last_s[c] = cyc;
            scnt[c]++;
         end
      end
   endtask

   initial begin
      int b0, b2;
      rst = 1'b0; run = 1'b0; sync = 1'b0; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_div = 8'd0;
      run_b = 1'b1; sync_b = 1'b0; cfg_we_b = 1'b0; cfg_ch_b = 2'd0; cfg_div_b = 4'd0;
      cyc = 0;
      for (int c = 0; c < 4; c++) begin
         last_s[c] = 0; intv[c] = 0; scnt[c] = 0;
      end
      repeat (2) @(negedge clk);
      check("reset_stb", 32'(stb), 32'h0);
      check("reset_tog", 32'(tog), 32'h0);
      check("reset_pending", 32'(cfg_pending), 32'h0);
      rst = 1'b1; run = 1'b1; chk_en = 1'b1;

      // Default divisors: periods 2, 4, 8, 16 over 32 edges.
      repeat (32) tick();
      check("def_cnt_ch0", 32'(scnt[0]), 32'd16);
      check("def_cnt_ch1", 32'(scnt[1]), 32'd8);
      check("def_cnt_ch2", 32'(scnt[2]), 32'd4);
      check("def_cnt_ch3", 32'(scnt[3]), 32'd2);
      check("def_intv_ch3", 32'(intv[3]), 32'd16);
      check("def_tog_edge32", 32'(tog), 32'h0);

      // Reprogram ch1 to 9 mid-period.
      tick();
      cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd9;
      tick();
      cfg_we = 1'b0;
      check("reprog_pending_up", 32'(cfg_pending[1]), 32'd1);
      repeat (2) tick();
      check("reprog_old_stb", 32'(stb[1]), 32'd1);
      check("reprog_old_intv", 32'(intv[1]), 32'd4);
      check("reprog_pending_dn", 32'(cfg_pending[1]), 32'd0);
      repeat (20) tick();
      check("reprog_new_stb", 32'(stb[1]), 32'd1);
      check("reprog_new_intv", 32'(intv[1]), 32'd10);

      // Write to ch2 during its terminal-count cycle (cyc 63 -> edge 64).
      repeat (7) tick();
      cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd2;
      tick();
      cfg_we = 1'b0;
      check("coll_stb", 32'(stb[2]), 32'd1);
      check("coll_intv", 32'(intv[2]), 32'd8);
      check("coll_pending", 32'(cfg_pending[2]), 32'd1);
      repeat (8) tick();
      check("coll_next_intv", 32'(intv[2]), 32'd8);
      check("coll_applied", 32'(cfg_pending[2]), 32'd0);
      repeat (3) tick();
      check("coll_new_intv", 32'(intv[2]), 32'd3);

      // Hold run low for 5 edges: ch3 strobe slips from 80 to 85.
      run = 1'b0;
      repeat (5) tick();
      check("run_low_stb", 32'(stb), 32'h0);
      run = 1'b1;
      repeat (5) tick();
      check("run_resume_stb", 32'(stb[3]), 32'd1);
      check("run_resume_intv", 32'(intv[3]), 32'd21);

      // Sync with direct writes: all channels to D = 0.
      sync = 1'b1; cfg_we = 1'b1; cfg_div = 8'd0;
      for (int c = 0; c < 4; c++) begin
         cfg_ch = 2'(c);
         tick();
      end
      sync = 1'b0; cfg_we = 1'b0;
      check("sync_stb", 32'(stb), 32'h0);
      check("sync_tog", 32'(tog), 32'h0);
      check("sync_pending", 32'(cfg_pending), 32'h0);
      tick();
      check("sync_first_stb", 32'(stb), 32'hF);
      check("sync_first_tog", 32'(tog), 32'hF);
      tick();
      check("d0_tog", 32'(tog), 32'h0);
      for (int k = 0; k < 8; k++) begin
         tick();
         check("d0_stb_high", 32'(stb), 32'hF);
      end

      // Maximum divisor on ch3.
      sync = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd255;
      tick();
      sync = 1'b0; cfg_we = 1'b0;
      repeat (255) tick();
      check("dmax_no_early", 32'(stb[3]), 32'd0);
      tick();
      check("dmax_first", 32'(stb[3]), 32'd1);
      repeat (256) tick();
      check("dmax_second", 32'(stb[3]), 32'd1);
      check("dmax_intv", 32'(intv[3]), 32'd256);

      // Out-of-range channel index on the 3-channel instance.
      cfg_we_b = 1'b1; cfg_ch_b = 2'd3; cfg_div_b = 4'd9;
      b0 = 0; b2 = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         b0 += int'(stb_b[0]);
         b2 += int'(stb_b[2]);
         check("oor_pending", 32'(pend_b), 32'h0);
      end
      cfg_we_b = 1'b0;
      check("oor_ch0_cnt", 32'(b0), 32'd30);
      check("oor_ch2_cnt", 32'(b2), 32'd10);

      // Asynchronous reset between edges.
      #2 rst = 1'b0;
      #1;
      check("areset_stb", 32'(stb), 32'h0);
      check("areset_tog", 32'(tog), 32'h0);
      check("areset_pending", 32'(cfg_pending), 32'h0);
      repeat (2) tick();
      rst = 1'b1;
      last_s[3] = cyc;
      repeat (15) tick();
      check("arel_no_early", 32'(stb[3]), 32'd0);
      tick();
      check("arel_first_ch3", 32'(stb[3]), 32'd1);
      check("arel_intv_ch3", 32'(intv[3]), 32'd16);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
